// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store unit over a word-wide memory port.
// Define LSU_ALIGN_CHECK_EN to trap misaligned accesses instead of force-aligning them.
module load_store_unit #(
   parameter int DEPTH = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);
   typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;
   state_t state, nxt;
   logic        uns_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wd_q;
   logic        oor, mis, bad;
   logic [4:0]  sh;
   logic [31:0] lane, mask, ext, merged;
   assign oor = req_addr >= 32'(DEPTH) * 32'd4;
`ifdef LSU_ALIGN_CHECK_EN
   assign mis = (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif
   assign bad = req_size == 2'b11 || oor || mis;
   // Half accesses ignore addr[0], which also force-aligns them when the check is off.
   assign sh     = size_q == 2'b00 ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
   assign lane   = mem_rd >> sh;
   assign mask   = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
   assign merged = (mem_rd & ~mask) | ((wd_q << sh) & mask);
   assign ext    = size_q == 2'b00 ? {{24{~uns_q & lane[7]}}, lane[7:0]} :
                   size_q == 2'b01 ? {{16{~uns_q & lane[15]}}, lane[15:0]} : mem_rd;
   assign req_ready  = state == IDLE;
   assign resp_valid = state == RESP;
   assign mem_we     = state == WRITE;
   assign mem_a      = {addr_q[31:2], 2'b00};
   assign mem_wd     = wd_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (req_valid) nxt = bad ? RESP : !req_we ? LOAD : req_size == 2'b10 ? WRITE : RMW_RD;
         LOAD:    nxt = RESP;
         RMW_RD:  nxt = WRITE;
         WRITE:   nxt = RESP;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         uns_q      <= 1'b0;
         size_q     <= 2'b00;
         addr_q     <= '0;
         wd_q       <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         if (state == IDLE && req_valid) begin
            uns_q  <= req_unsigned;
            size_q <= req_size;
            addr_q <= req_addr;
            wd_q   <= req_wdata;
         end
         if (state == RMW_RD) wd_q <= merged;
         if (nxt == RESP) begin
            resp_rdata <= state == LOAD ? ext : '0;
            resp_err   <= state == IDLE;
         end
      end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized scoreboard bench for load_store_unit against a byte-level memory model.
module tb_load_store_unit;
   localparam int DEPTH = 1024;
   logic        clk = 0, rst_n = 0, req_valid = 0, req_we = 0, req_unsigned = 0;
   logic [1:0]  req_size = 0;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic        req_ready, resp_valid, resp_err, mem_we;
   logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;
   logic [31:0] mem [DEPTH] = '{default: '0};
   logic [31:0] ref_mem [DEPTH] = '{default: '0};
   int cyc = 0, n_cmp = 0, n_bad = 0;
   typedef struct {logic [31:0] rdata; logic err; int cyc;} resp_t;
   typedef struct {logic [31:0] a; logic [31:0] d; int cyc;} wr_t;
   resp_t rq[$];
   wr_t   wq[$];
   resp_t e;
   wr_t   w;

   load_store_unit #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd));

   always #5 clk = ~clk;
   assign mem_rd = mem[mem_a[11:2]];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we) mem[mem_a[11:2]] <= mem_wd;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expected responses/writes whenever the DUT presents them.
   always @(negedge clk) if (rst_n) begin
      if (resp_valid) begin
         if (rq.size() == 0) check("unexpected_resp", 1, 0);
         else begin
            e = rq.pop_front();
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err", 32'(resp_err), 32'(e.err));
            check("resp_cycle", cyc, e.cyc);
         end
      end
      if (mem_we) begin
         if (wq.size() == 0) check("unexpected_mem_we", 1, 0);
         else begin
            w = wq.pop_front();
            check("mem_a", mem_a, w.a);
            check("mem_wd", mem_wd, w.d);
            check("write_cycle", cyc, w.cyc);
         end
      end
   end

   function automatic logic [7:0] rbyte(input int a);
      logic [31:0] x;
      x = ref_mem[a / 4];
      return x[8 * (a % 4) +: 8];
   endfunction

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr, input logic [31:0] wd);
      int t, n, base, acc;
      bit err;
      logic [31:0] v;
      resp_t r;
      wr_t x;
      t = 0;
      while (!req_ready && t < 20) begin @(negedge clk); t++; end
      if (!req_ready) begin check("ready_timeout", 0, 1); return; end
      acc = cyc;
      n = sz == 0 ? 1 : sz == 1 ? 2 : 4;
      err = sz == 3 || addr >= DEPTH * 4;
`ifdef LSU_ALIGN_CHECK_EN
      if (addr % n != 0) err = 1;
`endif
      base = int'(addr) - int'(addr % n);
      if (err) r = '{32'h0, 1'b1, acc + 1};
      else if (!we) begin
         v = 0;
         for (int i = 0; i < n; i++) v |= 32'(rbyte(base + i)) << (8 * i);
         if (!uns && n < 4 && v[8 * n - 1]) v |= ~32'h0 << (8 * n);
         r = '{v, 1'b0, acc + 2};
      end else begin
         for (int i = 0; i < n; i++) ref_mem[(base + i) / 4][8 * ((base + i) % 4) +: 8] = wd[8 * i +: 8];
         x = '{32'(base - base % 4), ref_mem[base / 4], acc + (n == 4 ? 1 : 2)};
         wq.push_back(x);
         r = '{32'h0, 1'b0, acc + (n == 4 ? 2 : 3)};
      end
      rq.push_back(r);
      req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
      @(negedge clk);
      req_valid = 0; req_we = $urandom; req_wdata = $urandom; req_addr = $urandom;
   endtask

   task automatic drain;
      int t;
      t = 0;
      while ((rq.size() != 0 || wq.size() != 0) && t < 50) begin @(negedge clk); t++; end
      if (rq.size() != 0 || wq.size() != 0) begin
         check("drain_timeout", 32'(rq.size() + wq.size()), 0);
         rq.delete(); wq.delete();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 1);
      check({tag, "_resp_valid"}, 32'(resp_valid), 0);
      check({tag, "_resp_rdata"}, resp_rdata, 0);
      check({tag, "_resp_err"}, 32'(resp_err), 0);
      check({tag, "_mem_we"}, 32'(mem_we), 0);
      check({tag, "_mem_a"}, mem_a, 0);
      check({tag, "_mem_wd"}, mem_wd, 0);
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0] sz;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1;
      @(negedge clk);
      check_reset_outputs("post_reset");
      issue(1, 2, 0, 32'h10, 32'hDEADBEEF);
      issue(0, 2, 0, 32'h10, 0);
      issue(1, 0, 0, 32'h13, 32'h000000A5);
      issue(0, 0, 0, 32'h13, 0);
      issue(0, 0, 1, 32'h13, 0);
      issue(1, 1, 0, 32'h12, 32'h00001234);
      issue(0, 1, 0, 32'h10, 0);
      issue(0, 1, 1, 32'h12, 0);
      issue(0, 2, 0, 32'h11, 0);
      issue(0, 3, 0, 32'h10, 0);
      issue(1, 3, 0, 32'h10, 32'h55555555);
      issue(1, 2, 0, 32'h1000, 32'h0BADF00D);
      issue(1, 2, 0, 32'h20, 32'hCAFEF00D);
      drain();
      // Reset during the read phase of a byte store must suppress the write.
      req_valid = 1; req_we = 1; req_size = 0; req_unsigned = 0; req_addr = 32'h20; req_wdata = 32'h77;
      @(negedge clk);
      req_valid = 0;
      rst_n = 0;
      #1 check_reset_outputs("abort");
      @(negedge clk);
      rst_n = 1;
      issue(0, 2, 0, 32'h20, 0);
      for (int k = 0; k < 300; k++) begin
         sz = 2'($urandom_range(0, 3));
         a = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
         if ($urandom_range(0, 19) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         issue(1'($urandom), sz, 1'($urandom), a, $urandom);
      end
      drain();
      for (int i = 0; i < 32; i++) check("mem_image", mem[i], ref_mem[i]);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
